// File: rtl/bf16_pkg.sv
// Shared BF16 constants, status-flag bit positions and the dot-accumulator state encoding.
package bf16_pkg;

    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_UNF   = 1;
    localparam int unsigned FLG_OVF   = 2;
    localparam int unsigned FLG_QNAN  = 3;
    localparam int unsigned FLG_SNAN  = 4;
    localparam int unsigned FLG_PINF  = 5;
    localparam int unsigned FLG_NINF  = 6;
    localparam int unsigned FLG_W     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bf16_fma.sv
// Combinational BF16 fused multiply-add, result = a*b + c with a single round-to-nearest-even.
// Subnormal inputs read as zero; tiny results flush to signed zero and raise underflow.
module bf16_fma
    import bf16_pkg::*;
(
    input  logic [15:0]      num_a,
    input  logic [15:0]      num_b,
    input  logic [15:0]      num_c,
    output logic [15:0]      result,
    output logic [FLG_W-1:0] flags
);
    localparam int unsigned WIN = 50;

    logic               sa, sb, sc, sp;
    logic [7:0]         ea, eb, ec;
    logic [6:0]         fa, fb, fc;
    logic               a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
    logic               any_snan, invalid;
    logic [15:0]        mp, xc;
    logic signed [11:0] ep, ecs;

    assign {sa, ea, fa} = num_a;
    assign {sb, eb, fb} = num_b;
    assign {sc, ec, fc} = num_c;
    assign sp       = sa ^ sb;
    assign a_zero   = (ea == 8'h00);
    assign b_zero   = (eb == 8'h00);
    assign c_zero   = (ec == 8'h00);
    assign a_inf    = (ea == 8'hFF) && (fa == 7'h00);
    assign b_inf    = (eb == 8'hFF) && (fb == 7'h00);
    assign c_inf    = (ec == 8'hFF) && (fc == 7'h00);
    assign a_nan    = (ea == 8'hFF) && (fa != 7'h00);
    assign b_nan    = (eb == 8'hFF) && (fb != 7'h00);
    assign c_nan    = (ec == 8'hFF) && (fc != 7'h00);
    assign any_snan = (a_nan && !fa[6]) || (b_nan && !fb[6]) || (c_nan && !fc[6]);
    assign invalid  = ((a_inf || b_inf) && (a_zero || b_zero))
                   || ((a_inf || b_inf) && c_inf && (sp != sc));

    // Product and addend share one fixed-point format: 16-bit significand, lead at bit 14/15
    assign mp  = 16'({1'b1, fa}) * 16'({1'b1, fb});
    assign xc  = c_zero ? 16'h0000 : {2'b01, fc, 7'b0};
    assign ep  = $signed({4'b0, ea}) + $signed({4'b0, eb}) - 12'sd127;
    assign ecs = $signed({4'b0, ec});

    logic               prod_big, s_big, s_small, st, mag_sign, inc, ovf, unf, qn;
    logic signed [11:0] e_big, d, er, er_r;
    logic [5:0]         dsh, p;
    logic [15:0]        x_big, x_small;
    logic [WIN-1:0]     big_full, small_full, sh, small_eff, mag;
    logic [WIN:0]       dd;
    logic [WIN-2:0]     norm;
    logic [8:0]         m_r;
    logic [6:0]         frac;
    logic [15:0]        res;

    always_comb begin
        prod_big   = c_zero || (ep >= ecs);
        e_big      = prod_big ? ep : ecs;
        d          = prod_big ? (ep - ecs) : (ecs - ep);
        x_big      = prod_big ? mp : xc;
        x_small    = prod_big ? xc : mp;
        s_big      = prod_big ? sp : sc;
        s_small    = prod_big ? sc : sp;
        big_full   = {1'b0, x_big, 33'b0};
        small_full = {1'b0, x_small, 33'b0};
        dsh        = '0;
        sh         = '0;
        st         = 1'b0;
        dd         = '0;
        mag        = '0;
        mag_sign   = 1'b0;
        p          = '0;
        res        = BF16_ZERO;
        ovf        = 1'b0;
        unf        = 1'b0;
        qn         = 1'b0;

        // Align the smaller term; anything shifted past bit 0 survives only as sticky
        if (d > 12'sd49) begin
            st = |x_small;
        end else begin
            dsh = 6'(d);
            sh  = small_full >> dsh;
            st  = |(small_full & ((WIN'(1) << dsh) - WIN'(1)));
        end
        small_eff = sh | WIN'(st);

        if (s_big == s_small) begin
            mag      = big_full + small_eff;
            mag_sign = s_big;
        end else begin
            dd = {1'b0, big_full} - {1'b0, small_eff};
            if (dd[WIN]) begin
                mag      = WIN'(-dd);
                mag_sign = s_small;
            end else begin
                mag      = dd[WIN-1:0];
                mag_sign = s_big;
            end
        end

        for (int i = 0; i < WIN; i++) begin
            if (mag[i]) p = 6'(i);
        end
        er   = $signed({6'b0, p}) + e_big - 12'sd47;
        norm = (WIN-1)'(mag << (6'(WIN - 1) - p));
        inc  = norm[41] && ((|norm[40:0]) || norm[42]);
        m_r  = {2'b01, norm[48:42]} + 9'(inc);
        frac = m_r[8] ? m_r[7:1] : m_r[6:0];
        er_r = er + $signed({11'b0, m_r[8]});

        if (a_nan || b_nan || c_nan || invalid) begin
            res = BF16_QNAN;
            qn  = 1'b1;
        end else if (a_inf || b_inf) begin
            res = {sp, 15'h7F80};
        end else if (c_inf) begin
            res = num_c;
        end else if (a_zero || b_zero) begin
            res = c_zero ? {sp & sc, 15'h0000} : num_c;
        end else if (mag == '0) begin
            res = BF16_ZERO;
        end else if (er_r >= 12'sd255) begin
            res = {mag_sign, 15'h7F80};
            ovf = 1'b1;
        end else if (er_r <= 12'sd0) begin
            res = {mag_sign, 15'h0000};
            unf = 1'b1;
        end else begin
            res = {mag_sign, er_r[7:0], frac};
        end
    end

    assign result          = res;
    assign flags[FLG_ZERO] = (res[14:0] == 15'h0000);
    assign flags[FLG_UNF]  = unf;
    assign flags[FLG_OVF]  = ovf;
    assign flags[FLG_QNAN] = qn;
    assign flags[FLG_SNAN] = any_snan;
    assign flags[FLG_PINF] = (res == 16'h7F80);
    assign flags[FLG_NINF] = (res == 16'hFF80);

endmodule

// File: rtl/bf16_dot_accumulator.sv
// Streams BF16 operand pairs into a registered FMA accumulator and presents the dot product.
// BF16_DOT_STICKY_FLAGS_EN: accumulate overflow/underflow/NaN flags across the whole vector.
module bf16_dot_accumulator
    import bf16_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [LEN_W-1:0] out_count,
    output logic [FLG_W-1:0] out_flags
);
    localparam logic [FLG_W-1:0] STICKY_MASK = (FLG_W'(1) << FLG_OVF) | (FLG_W'(1) << FLG_UNF)
                                             | (FLG_W'(1) << FLG_QNAN) | (FLG_W'(1) << FLG_SNAN);

    state_t           state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] count;
    logic [FLG_W-1:0] flags;
    logic [15:0]      fma_res;
    logic [FLG_W-1:0] fma_flags;
    logic [FLG_W-1:0] flags_next;
    logic             beat;

    bf16_fma u_fma (
        .num_a  (in_a),
        .num_b  (in_b),
        .num_c  (acc),
        .result (fma_res),
        .flags  (fma_flags)
    );

`ifdef BF16_DOT_STICKY_FLAGS_EN
    assign flags_next = fma_flags | (flags & STICKY_MASK);
`else
    assign flags_next = fma_flags | (flags & STICKY_MASK & '0);
`endif

    assign in_ready = !rst && (state != DONE);
    assign beat     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= BF16_ZERO;
            count     <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc       <= fma_res;
                        count     <= (&count) ? count : count + LEN_W'(1);
                        flags     <= flags_next;
                        state     <= in_last ? DONE : ACCUM;
                        out_valid <= in_last;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it, then the next vector starts from zero
                    if (out_ready) begin
                        acc       <= BF16_ZERO;
                        count     <= '0;
                        flags     <= '0;
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_result = acc;
    assign out_count  = count;
    assign out_flags  = flags;

endmodule

// File: tb/tb_bf16_dot_accumulator.sv
// Self-checking bench for bf16_dot_accumulator: directed cases plus random vectors
// compared against a double-precision reference rounded to BF16.
module tb_bf16_dot_accumulator;
    import bf16_pkg::*;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = 16'h0;
    logic [15:0]      in_b = 16'h0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_result;
    logic [LEN_W-1:0] out_count;
    logic [FLG_W-1:0] out_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bf16_dot_accumulator #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_flags  (out_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // BF16 <-> real, subnormals read as zero
    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] b;
        if (h[14:7] == 8'h00) b = {h[15], 63'd0};
        else                  b = {h[15], 11'(int'(h[14:7]) + 896), h[6:0], 45'd0};
        return $bitstoreal(b);
    endfunction

    // Round-to-nearest-even of a finite, in-range real to BF16
    function automatic logic [15:0] r2bf(input real x);
        logic [63:0] b;
        int          e;
        logic        rnd;
        logic [8:0]  m;
        b = $realtobits(x);
        if (b[62:0] == 63'd0) return {b[63], 15'h0000};
        e   = int'(b[62:52]) - 1023 + 127;
        rnd = b[44] && ((|b[43:0]) || b[45]);
        m   = {2'b01, b[51:45]} + 9'(rnd);
        if (m[8]) begin
            e++;
            m = m >> 1;
        end
        return {b[63], e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] rand_bf16();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom_range(0, 127))};
    endfunction

    // Present one beat at a negedge and return at the negedge after the accepting edge
    task automatic put(input logic [15:0] a, input logic [15:0] b, input logic last);
        int k = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_for_beat", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp_res, input int exp_cnt,
                              input logic [FLG_W-1:0] exp_flg, input int stall);
        int k = 0;
        in_valid = 1'b0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(exp_res));
        check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_flg));
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0]      a, b, acc_m;
        logic [FLG_W-1:0] flg_m;
        int               len, seen;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_result", 32'(out_result), 32'(BF16_ZERO));
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // 1*2 + 2*3 = 8
        put(16'h3F80, 16'h4000, 1'b0);
        put(16'h4000, 16'h4040, 1'b1);
        get_result("dot2", 16'h4100, 2, '0, 0);

        // Single beat, out_valid one cycle after acceptance
        in_a = 16'h4000; in_b = 16'h3F00; in_last = 1'b1; in_valid = 1'b1;
        check("single_pre_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_latency", 32'(out_valid), 32'd1);
        get_result("single", BF16_ONE, 1, '0, 0);

        // Output stall with a pending beat held by the source
        put(16'h3F80, 16'h4000, 1'b0);
        put(16'h4000, 16'h4040, 1'b1);
        in_a = 16'h3F80; in_b = 16'h3F80; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'(out_result), 32'h4100);
            check("stall_count", 32'(out_count), 32'd2);
            check("stall_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bubble_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        get_result("restart", BF16_ONE, 1, '0, 0);

        // Overflow to +inf, then a finite beat
        put(16'h7F00, 16'h7F00, 1'b0);
        put(16'h3F80, 16'h3F80, 1'b1);
`ifdef BF16_DOT_STICKY_FLAGS_EN
        flg_m = FLG_W'((1 << FLG_PINF) | (1 << FLG_OVF));
`else
        flg_m = FLG_W'(1 << FLG_PINF);
`endif
        get_result("ovf", 16'h7F80, 2, flg_m, 1);

        // Quiet NaN operand
        put(16'h7FC0, 16'h3F80, 1'b1);
        in_valid = 1'b0;
        check("qnan_valid", 32'(out_valid), 32'd1);
        check("qnan_is_nan", 32'((out_result[14:7] == 8'hFF) && (out_result[6:0] != 7'h00)), 32'd1);
        check("qnan_flags", 32'(out_flags), 32'(FLG_W'(1 << FLG_QNAN)));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-vector discards the partial sum
        put(16'h4000, 16'h4000, 1'b0);
        put(16'h4000, 16'h4000, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("rst_mid_no_output", 32'(seen), 32'd0);
        put(16'h3F80, 16'h3F80, 1'b1);
        get_result("after_rst", BF16_ONE, 1, '0, 0);

        // Random vectors against the real-arithmetic reference
        for (int v = 0; v < 12; v++) begin
            len   = int'($urandom_range(1, 5));
            acc_m = BF16_ZERO;
            for (int j = 0; j < len; j++) begin
                a = rand_bf16();
                b = rand_bf16();
                acc_m = r2bf(bf2r(a) * bf2r(b) + bf2r(acc_m));
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                put(a, b, (j == len - 1));
            end
            flg_m = (acc_m[14:0] == 15'h0) ? FLG_W'(1 << FLG_ZERO) : '0;
            get_result("rand", acc_m, len, flg_m, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bf16_dot_accumulator.md
# bf16_dot_accumulator

Sequential front end for the BF16 fused multiply-add unit: accepts a stream of BF16 operand pairs over a valid/ready handshake and folds each pair into a running accumulator, computing acc = a*b + acc per accepted beat. When the beat marked last is accepted, the block presents the dot-product result, the beat count and the status flags on a valid/ready output port. It sits directly upstream of the FMA, supplying a, b and the accumulator as c. It also registers the FMA's combinational result, so the dot-product path is one clean clocked stage.

## Interface
- LEN_W, 8, width of the beat counter; count saturates at 2^LEN_W-1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  16  BF16 multiplicand
- in_b  in  16  BF16 multiplier
- in_last  in  1  this beat is the final term of the vector
- out_valid  out  1  out_result, out_count and out_flags are valid
- out_ready  in  1  consumer accepts the result
- out_result  out  16  BF16 accumulated dot product
- out_count  out  LEN_W  number of beats accepted for this vector
- out_flags  out  7  {negative_inf, positive_inf, s_nan, q_nan, overflow, underflow, zero}

## Operation
- States:
  - IDLE: accumulator = 0x0000, count = 0.
  - ACCUM: at least one beat accepted, last not yet seen.
  - DONE: result held for the consumer.
- Beat accepted when in_valid && in_ready. in_ready = !rst && (state != DONE).
- On an accepted beat:
  - acc <= fma(in_a, in_b, acc).
  - count <= count+1, saturating at all-ones.
  - flags update (see Configuration).
- Accepted beat with in_last=0: IDLE/ACCUM -> ACCUM.
- Accepted beat with in_last=1: IDLE/ACCUM -> DONE.
- DONE:
  - out_valid=1.
  - out_result, out_count and out_flags are stable and in_ready=0 until out_valid && out_ready.
  - On that edge: acc <= 0x0000, count <= 0, flags <= 0, state -> IDLE.
- zero, positive_inf and negative_inf always reflect the current accumulator value.
- NaN or inf in the accumulator propagates through later beats; there is no early termination.
- A vector is at least one beat. A single-beat vector with in_last=1 is legal and yields a*b + 0.
- The sign of a zero result follows the FMA's rounding behaviour; the block does not normalise it.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, acc=0x0000, count=0, out_flags=0, out_valid=0, in_ready=0 while rst is high.
- Throughput: one beat per cycle while in ACCUM/IDLE.
- Latency: out_valid rises in the cycle after the edge that accepts the last beat.
- One-cycle bubble between vectors: the first beat of the next vector is accepted no earlier than the edge after the output handshake.
- Input-side backpressure: beats with in_valid=1 during DONE are not accepted; the source must hold them.
- Reset mid-vector: the partial accumulation is discarded and no output is produced.
- in_valid gaps during ACCUM leave all state unchanged.

## Configuration
- BF16_DOT_STICKY_FLAGS_EN defined:
  - overflow, underflow, q_nan and s_nan are OR-accumulated over every beat of the vector.
  - They clear only on the output handshake or on reset.
- Not defined: these four flags reflect only the most recently accepted beat.
- zero and inf flags are unaffected by the macro.

## Structure
- Shared package bf16_pkg holds:
  - BF16_ZERO = 16'h0000 and BF16_ONE = 16'h3F80.
  - Flag bit-index localparams (FLG_ZERO=0 … FLG_NINF=6).
  - State enum IDLE/ACCUM/DONE.
- One sub-module: bf16_fma, instantiated combinationally with num_a=in_a, num_b=in_b, num_c=acc. Its result and flag outputs are registered in this block.

## Test plan
- Beats (0x3F80, 0x4000), then (0x4000, 0x4040, last) -> out_result=0x4100 (8.0), out_count=2, out_flags=0.
- Single beat (0x4000, 0x3F00, last) -> out_result=0x3F80, out_count=1; out_valid rises exactly one cycle after acceptance.
- Same as the first case with out_ready held low for 3 cycles -> outputs stable, in_ready=0, a pending beat is not accepted; after the handshake, acc restarts from 0x0000.
- Beats (0x7F00, 0x7F00), then (0x3F80, 0x3F80, last):
  - Flag defined -> overflow=1 in out_flags.
  - Flag undefined -> overflow=0.
  - In both cases positive_inf=1 and out_result=0x7F80.
- Beat (0x7FC0, 0x3F80, last) -> q_nan=1, out_result is a NaN.
- Assert rst after 2 of 4 beats -> out_valid stays 0. A following vector (0x3F80, 0x3F80, last) yields out_result=0x3F80, out_count=1.
